incrementer_rr_scheduler: RTL and testbench
===========================================

// Module: incrementer_rr_scheduler
// PURPOSE
// - Shares one 4-bit ripple incrementer datapath (half-adder chain, carry-in tied 1) among NREQ requesters.
// - Round-robin arbitration; operand latched at grant; result, carry and requester ID returned with a one-cycle valid pulse.
// - Sits between client blocks needing occasional +1 ops (counters, address steppers) and the single shared incrementer.
// PARAMETERS
// - NREQ   4  number of requesters (2..8)
// - WIDTH  4  operand/result width; the datapath is a WIDTH-long half-adder chain
// PORTS
// - clk           in   1           rising-edge clock, only clock domain
// - rst_n         in   1           asynchronous, active-low reset
// - req           in   NREQ        per-requester request level; bit i = requester i
// - operand       in   NREQ*WIDTH  requester i operand at [i*WIDTH +: WIDTH]
// - grant         out  NREQ        one-hot, high for exactly the CALC cycle of the served requester
// - busy          out  1           high in CALC and DONE
// - result        out  WIDTH       operand+1 (see CONFIGURATION), valid only when result_valid=1
// - carry_out     out  1           final carry of the chain, valid with result_valid
// - result_id     out  $clog2(NREQ) index of the served requester, valid with result_valid
// - result_valid  out  1           single-cycle pulse in DONE
// BEHAVIOUR
// - Interface: one clock, clk; reset rst_n is asynchronous and active-low.
// - Reset (async assert, sync release): state=IDLE; grant=0, busy=0, result=0, carry_out=0, result_id=0,
//   result_valid=0; rr pointer=0 (requester 0 highest priority); operand register=0.
// - FSM states: IDLE -> CALC -> DONE -> IDLE. No other transitions except reset to IDLE from any state.
// - IDLE: if req!=0, select the first set bit searching from ptr, ptr+1, ... wrapping modulo NREQ;
//   latch that operand and index; go to CALC. If req==0, stay in IDLE.
// - CALC: grant[idx]=1, busy=1; the incrementer evaluates the latched operand; result and carry registered at end of cycle.
// - DONE: result_valid=1, busy=1, outputs hold the registered values; ptr <= (idx+1) mod NREQ; go to IDLE.
// - Latency: req sampled at edge N (in IDLE) -> grant high in cycle N..N+1 -> result_valid high in cycle N+1..N+2.
//   Throughput: one operation per 3 cycles under continuous demand.
// - Handshake: a requester holds req until it sees result_valid with its result_id, then drops req.
//   req still high when the FSM re-enters IDLE is treated as a new request.
// - req or operand changes after the IDLE sample edge are ignored for the current operation.
//   Dropping req in CALC or DONE does not cancel it; the result is still delivered.
// - Arithmetic: result = operand + 1 truncated to WIDTH bits; carry_out=1 iff operand was all ones.
// - Wrap case: operand=4'hF gives result=4'h0, carry_out=1 (default build).
// - Simultaneous requests: exactly one grant per operation; no requester waits more than NREQ-1 operations.
// - Reset mid-operation: the in-flight op is discarded, no result_valid is produced, ptr returns to 0.
// - Outputs other than result_valid/grant/busy keep their last values in IDLE; consumers must gate on result_valid.
// CONFIGURATION
// - Macro INC_SATURATE_EN.
// - Defined: if the operand is all ones, result=all ones (saturate) and carry_out=1 acts as an overflow flag.
//   All other operands behave as in the default build.
// - Undefined (default): modulo-2^WIDTH wrap as described above.
// - No other macro or parameter changes the FSM or arbitration.
// TESTING
// - Reset: rst_n=0 with req=4'b1111 -> all outputs 0, no grant; release -> first grant to requester 0.
// - Single request: req=4'b0100, operand[11:8]=4'h6 -> grant=4'b0100 one cycle later;
//   then result=4'h7, carry_out=0, result_id=2, result_valid one cycle.
// - Wrap: requester 1 operand=4'hF -> result=4'h0, carry_out=1.
//   With INC_SATURATE_EN defined -> result=4'hF, carry_out=1.
// - Round robin: req=4'b1111 held, all operands=4'h3 -> result_id sequence 0,1,2,3,0, each result=4'h4,
//   result_valid every 3 cycles.
// - Late change: req=4'b0001, operand=4'h2; change operand to 4'h9 and drop req during CALC -> result=4'h3 still delivered.
// - Reset mid-op: assert rst_n=0 during CALC -> no result_valid; after release req=4'b1000 -> result_id=3, normal latency.

Source files
------------

// File: rtl/incrementer_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : incrementer_rr_scheduler
// Purpose  : Round-robin scheduler sharing one WIDTH-bit ripple incrementer
//            among NREQ requesters. Optional macro: INC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module incrementer_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   operand,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [WIDTH-1:0]        result,
  output logic                    carry_out,
  output logic [$clog2(NREQ)-1:0] result_id,
  output logic                    result_valid
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   sel_idx;
  logic             sel_found;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] res_calc;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int k);
    int s;
    s = (int'(a) + k) % NREQ;
    return s[IDW-1:0];
  endfunction

  // First requester at or after ptr, wrapping around.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_found && req[wrap_add(ptr, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr, k);
      end
    end
  end

  // Half-adder chain with carry-in tied high.
  assign carry[0] = 1'b1;
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
      assign sum[i]     = op_q[i] ^ carry[i];
      assign carry[i+1] = op_q[i] & carry[i];
    end
  endgenerate

`ifdef INC_SATURATE_EN
  assign res_calc = carry[WIDTH] ? {WIDTH{1'b1}} : sum;
`else
  assign res_calc = sum;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sel_found) state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      idx       <= '0;
      op_q      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      result_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            idx  <= sel_idx;
            op_q <= operand[int'(sel_idx)*WIDTH +: WIDTH];
          end
        end
        ST_CALC: begin
          result    <= res_calc;
          carry_out <= carry[WIDTH];
          result_id <= idx;
        end
        ST_DONE: ptr <= wrap_add(idx, 1);
        default: ;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    if (state == ST_CALC) grant[idx] = 1'b1;
  end

  assign busy         = (state != ST_IDLE);
  assign result_valid = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_incrementer_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_incrementer_rr_scheduler
// Purpose  : Self-checking bench with a transaction-level scheduler model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_incrementer_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] operand = '0;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      result;
  logic                  carry_out;
  logic [IDW-1:0]        result_id;
  logic                  result_valid;

  incrementer_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .operand      (operand),
    .grant        (grant),
    .busy         (busy),
    .result       (result),
    .carry_out    (carry_out),
    .result_id    (result_id),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: an op starts on any edge where the shared unit
  // is free and someone requests; it occupies the unit for three cycles.
  int cyc      = 0;
  int free_at  = 0;
  int ptr_m    = 0;
  int tx_start = 0;
  int tx_id    = 0;
  int tx_op    = 0;
  bit tx_valid = 1'b0;
  int last_res = 0;
  int last_c   = 0;
  int last_id  = 0;

  function automatic int model_inc(input int op);
    int mask = (1 << WIDTH) - 1;
`ifdef INC_SATURATE_EN
    return (op == mask) ? mask : op + 1;
`else
    return (op + 1) & mask;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; free_at = 0; ptr_m = 0; tx_valid = 1'b0;
      last_res = 0; last_c = 0; last_id = 0;
    end else begin
      cyc++;
      if (tx_valid && cyc == tx_start + 1) begin
        last_res = model_inc(tx_op);
        last_c   = (tx_op == (1 << WIDTH) - 1) ? 1 : 0;
        last_id  = tx_id;
      end
      if (cyc >= free_at && req != '0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req[(ptr_m + k) % NREQ]) tx_id = (ptr_m + k) % NREQ;
        tx_op    = int'(operand[tx_id*WIDTH +: WIDTH]);
        tx_start = cyc;
        tx_valid = 1'b1;
        free_at  = cyc + 3;
        ptr_m    = (tx_id + 1) % NREQ;
      end
    end
  end

  int d;
  always @(negedge clk) begin
    d = (rst_n && tx_valid) ? cyc - tx_start : -1;
    check("grant",        32'(grant),        (d == 0) ? (32'd1 << tx_id) : 32'd0);
    check("busy",         32'(busy),         (d == 0 || d == 1) ? 32'd1 : 32'd0);
    check("result_valid", 32'(result_valid), (d == 1) ? 32'd1 : 32'd0);
    check("result",       32'(result),       32'(last_res));
    check("carry_out",    32'(carry_out),    32'(last_c));
    check("result_id",    32'(result_id),    32'(last_id));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    req     = 4'b1111;
    operand = 16'($urandom);
    tick(3);
    rst_n = 1'b1;
    tick(8);
    req = '0;
    tick(4);

    // Single request from requester 2
    req = 4'b0100; operand = 16'h0600;
    tick(2); req = '0; tick(3);

    // Wrap from requester 1
    req = 4'b0010; operand = 16'h00F0;
    tick(2); req = '0; tick(3);

    // Round robin under full demand
    req = 4'b1111; operand = 16'h3333;
    tick(16); req = '0; tick(3);

    // Operand and request change after the sample edge
    req = 4'b0001; operand = 16'h0002;
    tick(1); operand = 16'h0009; req = '0;
    tick(4);

    // Move the pointer, then reset mid-op and confirm it returns to 0
    req = 4'b0010; operand = 16'h0050;
    tick(2); req = '0; tick(2);
    req = 4'b0100; operand = 16'h0500;
    tick(1); rst_n = 1'b0; req = '0;
    tick(2); rst_n = 1'b1;
    req = 4'b1001; operand = 16'hA00C;
    tick(2); req = '0; tick(3);
    req = 4'b1000; operand = 16'h7000;
    tick(2); req = '0; tick(3);

    // Random traffic following the handshake
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && result_valid && int'(result_id) == i) req[i] = 1'b0;
        else if (!req[i] && ($urandom % 4) == 0) req[i] = 1'b1;
      end
      operand = 16'($urandom);
      tick(1);
    end
    req = '0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
